// File: rtl/cmp_branch_unit_if.sv
// Branch request and branch result channels between the requester and cmp_branch_unit.
interface cmp_branch_unit_if #(
    parameter int unsigned PC_W = 16
);
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_offset;
    logic [PC_W-1:0] pc_in;
    logic            res_valid;
    logic            res_ready;
    logic            res_taken;
    logic [PC_W-1:0] res_pc;

    // Requester side: issues branches, consumes results.
    modport master (
        output br_valid, br_cond, br_offset, pc_in, res_ready,
        input  br_ready, res_valid, res_taken, res_pc
    );

    // Unit side: accepts branches, produces results.
    modport slave (
        input  br_valid, br_cond, br_offset, pc_in, res_ready,
        output br_ready, res_valid, res_taken, res_pc
    );
endinterface

// File: rtl/cmp_branch_unit.sv
// Latches comparator flags and resolves conditional branches into a
// taken decision and next PC through a one-entry valid/ready stage.
module cmp_branch_unit #(
    parameter int unsigned PC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag_we,
    input  logic                 cmp_gt,
    input  logic                 cmp_eq,
    input  logic                 cmp_lt,
    cmp_branch_unit_if.slave     bus,
    output logic [2:0]           flags_out,
    output logic                 flags_valid,
    output logic                 flag_err
);
    localparam int unsigned FLAG_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic [FLAG_W-1:0] cmp_vec;
    logic              flag_legal;
    logic [FLAG_W-1:0] eval_flags;
    logic              cond_true;
    logic              accept;
    logic [PC_W-1:0]   next_pc;

    assign cmp_vec = {cmp_gt, cmp_eq, cmp_lt};

    // A flag write is usable only when exactly one comparator flag is set.
    always_comb begin
        flag_legal = 1'b0;
        if (flag_we && (cmp_vec == 3'b100 || cmp_vec == 3'b010 || cmp_vec == 3'b001)) begin
            flag_legal = 1'b1;
        end
    end

    // Condition evaluation, forwarding a same-cycle legal flag write.
    always_comb begin
        eval_flags = flags_out;
        if (flag_legal) begin
            eval_flags = cmp_vec;
        end
        cond_true = 1'b0;
        case (bus.br_cond)
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = eval_flags[1];
            3'b010:  cond_true = !eval_flags[1];
            3'b011:  cond_true = eval_flags[0];
            3'b100:  cond_true = eval_flags[2] | eval_flags[1];
            3'b101:  cond_true = eval_flags[2];
            3'b110:  cond_true = eval_flags[0] | eval_flags[1];
            default: cond_true = 1'b1;
        endcase
    end

    // Next PC; offset already spans PC_W bits so sign extension is implicit.
    always_comb begin
        next_pc = bus.pc_in + PC_W'(1);
        if (cond_true) begin
            next_pc = bus.pc_in + bus.br_offset;
        end
    end

    // Ready whenever the output slot is free or being drained this cycle.
    assign bus.br_ready = flags_valid && (state == EMPTY || bus.res_ready);
    assign accept       = bus.br_valid && bus.br_ready;

    // Flag register with sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_out   <= '0;
            flags_valid <= 1'b0;
            flag_err    <= 1'b0;
        end else if (flag_we) begin
            if (flag_legal) begin
                flags_out   <= cmp_vec;
                flags_valid <= 1'b1;
            end else begin
                flag_err    <= 1'b1;
            end
        end
    end

    // Output stage state machine with registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            bus.res_valid <= 1'b0;
            bus.res_taken <= 1'b0;
            bus.res_pc    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state         <= FULL;
                        bus.res_valid <= 1'b1;
                        bus.res_taken <= cond_true;
                        bus.res_pc    <= next_pc;
                    end
                end
                FULL: begin
                    if (accept) begin
                        bus.res_taken <= cond_true;
                        bus.res_pc    <= next_pc;
                    end else if (bus.res_ready) begin
                        state         <= EMPTY;
                        bus.res_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    bus.res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_branch_unit.sv
// Self-checking bench for cmp_branch_unit: directed scenarios plus random traffic
// against a behavioural model of flags, conditions and the result slot.
module tb_cmp_branch_unit;
    logic        clk;
    logic        rst;
    logic        flag_we;
    logic        cmp_gt;
    logic        cmp_eq;
    logic        cmp_lt;
    logic [2:0]  flags_out;
    logic        flags_valid;
    logic        flag_err;

    int checks   = 0;
    int failures = 0;

    cmp_branch_unit_if #(.PC_W(16)) bus ();

    cmp_branch_unit #(.PC_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .flag_we     (flag_we),
        .cmp_gt      (cmp_gt),
        .cmp_eq      (cmp_eq),
        .cmp_lt      (cmp_lt),
        .bus         (bus),
        .flags_out   (flags_out),
        .flags_valid (flags_valid),
        .flag_err    (flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state.
    bit          m_known = 1'b0;
    bit          m_full;
    bit          m_taken;
    int unsigned m_pc;
    bit [2:0]    m_flags;
    bit          m_fv;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stored flags as a signed relation A vs B.
    function automatic int rel_of(input bit [2:0] f);
        if (f[2]) return 1;
        if (f[0]) return -1;
        return 0;
    endfunction

    function automatic bit cond_holds(input int c, input int rel);
        case (c)
            0: return 1'b0;
            1: return rel == 0;
            2: return rel != 0;
            3: return rel < 0;
            4: return rel >= 0;
            5: return rel > 0;
            6: return rel <= 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int unsigned pc_calc(input bit tk, input int unsigned pc, input int unsigned off);
        int s;
        int t;
        s = (off >= 32768) ? int'(off) - 65536 : int'(off);
        t = tk ? int'(pc) + s : int'(pc) + 1;
        return int'((t + 65536) % 65536);
    endfunction

    function automatic bit model_ready(input bit rr);
        return m_fv && (!m_full || rr);
    endfunction

    // One clock: drive at negedge, check ready, advance model, check registered outputs.
    task automatic step(input bit we, input bit [2:0] f, input bit bv, input bit [2:0] cond,
                        input bit [15:0] off, input bit [15:0] pc, input bit rr, input bit r);
        bit       exp_rdy;
        bit       legal;
        bit [2:0] use_f;
        rst           = r;
        flag_we       = we;
        {cmp_gt, cmp_eq, cmp_lt} = f;
        bus.br_valid  = bv;
        bus.br_cond   = cond;
        bus.br_offset = off;
        bus.pc_in     = pc;
        bus.res_ready = rr;
        #1;
        exp_rdy = model_ready(rr);
        if (m_known) chk("br_ready", 32'(bus.br_ready), 32'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_full = 0; m_taken = 0; m_pc = 0; m_flags = 0; m_fv = 0; m_err = 0; m_known = 1;
        end else if (m_known) begin
            legal = we && ($countones(f) == 1);
            if (bv && exp_rdy) begin
                use_f   = legal ? f : m_flags;
                m_taken = cond_holds(int'(cond), rel_of(use_f));
                m_pc    = pc_calc(m_taken, int'(pc), int'(off));
                m_full  = 1;
            end else if (m_full && rr) begin
                m_full = 0;
            end
            if (we) begin
                if (legal) begin m_flags = f; m_fv = 1; end
                else m_err = 1;
            end
        end
        @(negedge clk);
        if (m_known) begin
            chk("res_valid",   32'(bus.res_valid), 32'(m_full));
            chk("res_taken",   32'(bus.res_taken), 32'(m_taken));
            chk("res_pc",      32'(bus.res_pc),    m_pc);
            chk("flags_out",   32'(flags_out),     32'(m_flags));
            chk("flags_valid", 32'(flags_valid),   32'(m_fv));
            chk("flag_err",    32'(flag_err),      32'(m_err));
        end
    endtask

    initial begin
        bit [2:0] f;
        @(negedge clk);
        // Reset.
        step(0, 3'b000, 0, 3'd0, 16'h0, 16'h0, 1, 1);
        step(0, 3'b000, 0, 3'd0, 16'h0, 16'h0, 1, 1);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_flags", 32'(flags_out), 32'd0);
        chk("rst_err", 32'(flag_err), 32'd0);

        // Requests stall until flags are valid, even ALWAYS.
        for (int i = 0; i < 5; i++) begin
            step(0, 3'b000, 1, 3'd7, 16'h0, 16'h0, 1, 0);
            chk("stall_ready", 32'(bus.br_ready), 32'd0);
            chk("stall_valid", 32'(bus.res_valid), 32'd0);
        end

        // EQ taken / NE not taken.
        step(1, 3'b010, 0, 3'd0, 16'h0, 16'h0, 1, 0);
        step(0, 3'b000, 1, 3'd1, 16'h0010, 16'h0100, 1, 0);
        chk("eq_taken", 32'(bus.res_taken), 32'd1);
        chk("eq_pc", 32'(bus.res_pc), 32'h0110);
        step(0, 3'b000, 1, 3'd2, 16'h0010, 16'h0100, 1, 0);
        chk("ne_taken", 32'(bus.res_taken), 32'd0);
        chk("ne_pc", 32'(bus.res_pc), 32'h0101);

        // Wrap in both directions.
        step(1, 3'b001, 0, 3'd0, 16'h0, 16'h0, 1, 0);
        step(0, 3'b000, 1, 3'd3, 16'h0010, 16'hFFF8, 1, 0);
        chk("wrap_up_pc", 32'(bus.res_pc), 32'h0008);
        step(0, 3'b000, 1, 3'd3, 16'hFFF0, 16'h0004, 1, 0);
        chk("wrap_dn_pc", 32'(bus.res_pc), 32'hFFF4);

        // Forwarding of a legal same-cycle write; no forwarding of an illegal one.
        step(1, 3'b100, 1, 3'd5, 16'h0002, 16'h0200, 1, 0);
        chk("fwd_taken", 32'(bus.res_taken), 32'd1);
        step(1, 3'b001, 0, 3'd0, 16'h0, 16'h0, 1, 0);
        step(1, 3'b110, 1, 3'd3, 16'h0002, 16'h1234, 1, 0);
        chk("ill_taken", 32'(bus.res_taken), 32'd1);
        chk("ill_err", 32'(flag_err), 32'd1);
        chk("ill_flags", 32'(flags_out), 32'h1);
        chk("ill_pc", 32'(bus.res_pc), 32'h1236);

        // Back-pressure hold, flag write during hold, then drain plus accept.
        for (int i = 0; i < 3; i++) begin
            step(i == 1, 3'b010, 1, 3'd0, 16'h0, 16'h2000, 0, 0);
            chk("hold_ready", 32'(bus.br_ready), 32'd0);
            chk("hold_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_taken", 32'(bus.res_taken), 32'd1);
            chk("hold_pc", 32'(bus.res_pc), 32'h1236);
        end
        step(0, 3'b000, 1, 3'd0, 16'h0, 16'h2000, 1, 0);
        chk("drain_valid", 32'(bus.res_valid), 32'd1);
        chk("drain_taken", 32'(bus.res_taken), 32'd0);
        chk("drain_pc", 32'(bus.res_pc), 32'h2001);

        // Reset while full with an error latched; reset beats flag_we and br_valid.
        step(0, 3'b000, 0, 3'd0, 16'h0, 16'h0, 0, 1);
        chk("mrst_valid", 32'(bus.res_valid), 32'd0);
        chk("mrst_flags", 32'(flags_out), 32'd0);
        chk("mrst_fv", 32'(flags_valid), 32'd0);
        chk("mrst_err", 32'(flag_err), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
            else f = 3'(1 << $urandom_range(0, 2));
            step($urandom_range(0, 9) < 3, f, $urandom_range(0, 9) < 6,
                 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmp_branch_unit.md
# cmp_branch_unit

Sequential consumer of the 16-bit magnitude comparator's three flag outputs. It latches the comparator's greater/equal/less result into a flag register, checks it for consistency, and resolves conditional-branch requests against the stored flags. For each request it produces a taken/not-taken decision and the next 16-bit PC, over a one-entry valid/ready output stage. It sits between the comparator and the program-counter/fetch logic.

## Interface
- PC_W, 16, PC and offset width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flag_we  in  1  capture cmp_* into flag register this cycle
- cmp_gt  in  1  comparator A_greater_B
- cmp_eq  in  1  comparator A_equal_B
- cmp_lt  in  1  comparator A_less_B
- br_valid  in  1  branch request present
- br_ready  out  1  request accepted when br_valid && br_ready
- br_cond  in  3  condition code (see Operation)
- br_offset  in  PC_W  signed two's-complement branch offset
- pc_in  in  PC_W  PC of the branch instruction
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result when res_valid && res_ready
- res_taken  out  1  condition evaluated true
- res_pc  out  PC_W  next PC
- flags_out  out  3  registered flags {gt,eq,lt}
- flags_valid  out  1  at least one legal flag write since reset
- flag_err  out  1  sticky illegal-flag indicator

## Operation
- Legal flag write: flag_we=1 and {cmp_gt,cmp_eq,cmp_lt} is exactly one-hot.
  - flags_out takes the new value next cycle; flags_valid goes to 1.
- Illegal flag write: flag_we=1 and the flags are not one-hot (000, 011, 101, 110, 111).
  - flags_out is unchanged; flag_err is set to 1 and stays set until rst.
- Condition codes:
  - 000 NEVER
  - 001 EQ: eq
  - 010 NE: !eq
  - 011 LT: lt
  - 100 GE: gt|eq
  - 101 GT: gt
  - 110 LE: lt|eq
  - 111 ALWAYS
- Flag forwarding: if a legal flag write and a request acceptance occur in the same cycle, the condition is evaluated on the incoming cmp_* values. An illegal write in that cycle is not forwarded; the stored flags are used.
- res_pc = taken ? pc_in + br_offset : pc_in + 1. Arithmetic is modulo 2^PC_W; overflow wraps silently. The offset is sign-extended to PC_W, which is a no-op at the default width.
- Output state machine:
  - EMPTY: res_valid=0. An accepted request goes to FULL.
  - FULL: res_valid=1. If res_ready and a new request is accepted, stay in FULL with the new result. If res_ready and no new request is accepted, go to EMPTY. If !res_ready, hold.
- br_ready = flags_valid && (state==EMPTY || res_ready). Requests stall until the first legal flag write, including NEVER/ALWAYS.
- While FULL && !res_ready: res_taken and res_pc remain stable. Flag writes still proceed and do not alter the held result.

## Timing
- Reset values:
  - state EMPTY, res_valid 0, res_taken 0, res_pc 0
  - flags_out 000, flags_valid 0, flag_err 0
  - br_ready 0
- Flag write to flags_out/flags_valid: 1 cycle.
- Request acceptance to res_valid: 1 cycle. Back-to-back throughput is 1 result per cycle while res_ready=1.
- br_ready is combinational from state, flags_valid and res_ready. All other outputs are registered.
- rst mid-operation: a pending result is discarded and res_valid drops the next cycle. Flags, flags_valid and flag_err all clear.
- rst dominates flag_we and br_valid in the same cycle.

## Test plan
- Reset, then br_valid=1 cond=111 with no flag write: br_ready stays 0 for 5 cycles and res_valid stays 0.
- flag_we with gt/eq/lt=010, next cycle request cond=001, pc_in=0x0100, offset=0x0010: res_taken=1, res_pc=0x0110. Same setup with cond=010: res_taken=0, res_pc=0x0101.
- Flags 001 (lt), cond=011, pc_in=0xFFF8, offset=0x0010: res_pc=0x0008 (wrap). Repeat with offset=0xFFF0 (−16) and pc_in=0x0004: res_pc=0xFFF4.
- Same-cycle legal flag_we 100 plus request cond=101 while stored flags are 001: res_taken=1. Same-cycle illegal flag_we 110 plus request cond=011 with stored flags 001: res_taken=1 (stored flags used), flag_err=1, flags_out stays 001.
- res_ready=0 for 3 cycles after a result: res_valid, res_taken and res_pc are held, and br_ready=0. Then raise res_ready with a new request pending: result 1 is consumed, the new request is accepted in the same cycle, and result 2 appears the next cycle.
- Assert rst while FULL with flag_err=1: the next cycle res_valid=0, flags_out=000, flags_valid=0, flag_err=0.
